// File: rtl/clock_pkg.sv
// Shared constants for the calendar/clock datapath: field widths,
// month numbers and the manual-adjust field select encodings.
package clock_pkg;

  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;

  localparam logic [MONTH_W-1:0] MON_JAN = 4'd1;
  localparam logic [MONTH_W-1:0] MON_FEB = 4'd2;
  localparam logic [MONTH_W-1:0] MON_MAR = 4'd3;
  localparam logic [MONTH_W-1:0] MON_APR = 4'd4;
  localparam logic [MONTH_W-1:0] MON_MAY = 4'd5;
  localparam logic [MONTH_W-1:0] MON_JUN = 4'd6;
  localparam logic [MONTH_W-1:0] MON_JUL = 4'd7;
  localparam logic [MONTH_W-1:0] MON_AUG = 4'd8;
  localparam logic [MONTH_W-1:0] MON_SEP = 4'd9;
  localparam logic [MONTH_W-1:0] MON_OCT = 4'd10;
  localparam logic [MONTH_W-1:0] MON_NOV = 4'd11;
  localparam logic [MONTH_W-1:0] MON_DEC = 4'd12;

  localparam logic [1:0] ADJ_DAY   = 2'd0;
  localparam logic [1:0] ADJ_MONTH = 2'd1;
  localparam logic [1:0] ADJ_YEAR  = 2'd2;
  localparam logic [1:0] ADJ_NONE  = 2'd3;

endpackage

// File: rtl/month_length.sv
// Combinational month length and leap flag for a (month, year offset) pair.
// Out-of-range month codes report 31; callers validate the month separately.
module month_length
  import clock_pkg::*;
#(
  parameter int YEAR_W       = 7,
  parameter int BASE_YEAR    = 2000,
  parameter int CENTURY_RULE = 1
) (
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   length,
  output logic               leap
);

  logic [11:0] full_year;
  logic        div4;
  logic        div100;
  logic        div400;

  assign full_year = 12'(BASE_YEAR) + 12'(year);
  assign div4      = (full_year[1:0] == 2'b00);
  assign div100    = ((full_year % 12'd100) == 12'd0);
  assign div400    = ((full_year % 12'd400) == 12'd0);

  always_comb begin
    leap = div4 && ((CENTURY_RULE == 0) || !div100 || div400);
    case (month)
      MON_FEB:                            length = leap ? 5'd29 : 5'd28;
      MON_APR, MON_JUN, MON_SEP, MON_NOV: length = 5'd30;
      default:                            length = 5'd31;
    endcase
  end

endmodule

// File: rtl/calendar_date_counter.sv
// Day/month/year calendar register: advances on day_tick, accepts validated
// loads and per-field button adjusts that clamp the day instead of carrying.
module calendar_date_counter
  import clock_pkg::*;
#(
  parameter int YEAR_W       = 7,
  parameter int BASE_YEAR    = 2000,
  parameter int CENTURY_RULE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                day_tick,
  input  logic                load_valid,
  input  logic [DAY_W-1:0]    load_day,
  input  logic [MONTH_W-1:0]  load_month,
  input  logic [YEAR_W-1:0]   load_year,
  input  logic                adj_pulse,
  input  logic [1:0]          adj_sel,
  output logic [DAY_W-1:0]    day,
  output logic [MONTH_W-1:0]  month,
  output logic [YEAR_W-1:0]   year,
  output logic [DAY_W-1:0]    days_in_month,
  output logic                leap,
  output logic                load_ack,
  output logic                load_err,
  output logic                month_wrap,
  output logic                year_wrap
);

  logic [DAY_W-1:0]   day_q, day_d;
  logic [MONTH_W-1:0] month_q, month_d;
  logic [YEAR_W-1:0]  year_q, year_d;
  logic               load_ack_q, load_ack_d;
  logic               load_err_q, load_err_d;
  logic               month_wrap_q, month_wrap_d;
  logic               year_wrap_q, year_wrap_d;

  logic [DAY_W-1:0]   cur_len, ld_len, cand_len;
  logic               cur_leap, ld_leap_unused, cand_leap_unused;
  logic [MONTH_W-1:0] next_month, cand_month;
  logic [YEAR_W-1:0]  next_year, cand_year;
  logic               load_ok;

  assign next_month = (month_q == MON_DEC) ? MON_JAN : month_q + 4'd1;
  assign next_year  = year_q + 1'b1;

  // One shared instance evaluates whichever candidate date the adjust would create.
  assign cand_month = (adj_sel == ADJ_MONTH) ? next_month : month_q;
  assign cand_year  = (adj_sel == ADJ_YEAR)  ? next_year  : year_q;

  month_length #(.YEAR_W(YEAR_W), .BASE_YEAR(BASE_YEAR), .CENTURY_RULE(CENTURY_RULE)) u_cur_len (
    .month(month_q), .year(year_q), .length(cur_len), .leap(cur_leap)
  );

  month_length #(.YEAR_W(YEAR_W), .BASE_YEAR(BASE_YEAR), .CENTURY_RULE(CENTURY_RULE)) u_load_len (
    .month(load_month), .year(load_year), .length(ld_len), .leap(ld_leap_unused)
  );

  month_length #(.YEAR_W(YEAR_W), .BASE_YEAR(BASE_YEAR), .CENTURY_RULE(CENTURY_RULE)) u_cand_len (
    .month(cand_month), .year(cand_year), .length(cand_len), .leap(cand_leap_unused)
  );

  assign load_ok = (load_month >= MON_JAN) && (load_month <= MON_DEC) &&
                   (load_day != 5'd0) && (load_day <= ld_len);

  always_comb begin
    day_d        = day_q;
    month_d      = month_q;
    year_d       = year_q;
    load_ack_d   = 1'b0;
    load_err_d   = 1'b0;
    month_wrap_d = 1'b0;
    year_wrap_d  = 1'b0;

    if (load_valid) begin
      if (load_ok) begin
        day_d      = load_day;
        month_d    = load_month;
        year_d     = load_year;
        load_ack_d = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (adj_pulse) begin
      case (adj_sel)
        ADJ_DAY: day_d = (day_q >= cur_len) ? 5'd1 : day_q + 5'd1;
        ADJ_MONTH: begin
          month_d = next_month;
          day_d   = (day_q > cand_len) ? cand_len : day_q;
        end
        ADJ_YEAR: begin
          year_d = next_year;
          day_d  = (day_q > cand_len) ? cand_len : day_q;
        end
        default: ;
      endcase
    end else if (day_tick) begin
      if (day_q < cur_len) begin
        day_d = day_q + 5'd1;
      end else begin
        day_d        = 5'd1;
        month_wrap_d = 1'b1;
        if (month_q == MON_DEC) begin
          month_d     = MON_JAN;
          year_d      = next_year;
          year_wrap_d = (year_q == {YEAR_W{1'b1}});
        end else begin
          month_d = next_month;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      day_q        <= 5'd1;
      month_q      <= MON_JAN;
      year_q       <= '0;
      load_ack_q   <= 1'b0;
      load_err_q   <= 1'b0;
      month_wrap_q <= 1'b0;
      year_wrap_q  <= 1'b0;
    end else begin
      day_q        <= day_d;
      month_q      <= month_d;
      year_q       <= year_d;
      load_ack_q   <= load_ack_d;
      load_err_q   <= load_err_d;
      month_wrap_q <= month_wrap_d;
      year_wrap_q  <= year_wrap_d;
    end
  end

  assign day           = day_q;
  assign month         = month_q;
  assign year          = year_q;
  assign days_in_month = cur_len;
  assign leap          = cur_leap;
  assign load_ack      = load_ack_q;
  assign load_err      = load_err_q;
  assign month_wrap    = month_wrap_q;
  assign year_wrap     = year_wrap_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Scoreboard bench: the driver queues a hand-computed expected state per cycle,
// the monitor pops and compares after each clock edge.
module tb_calendar_date_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       day_tick = 1'b0;
  logic       load_valid = 1'b0;
  logic [4:0] load_day = '0;
  logic [3:0] load_month = '0;
  logic [6:0] load_year = '0;
  logic       adj_pulse = 1'b0;
  logic [1:0] adj_sel = '0;

  logic [4:0] day, dim;
  logic [3:0] month;
  logic [6:0] year;
  logic       leap, load_ack, load_err, month_wrap, year_wrap;

  logic [4:0] day0, dim0;
  logic [3:0] month0;
  logic [6:0] year0;
  logic       leap0, ack0, err0, mw0, yw0;

  always #5 clk = ~clk;

  calendar_date_counter #(.YEAR_W(7), .BASE_YEAR(2000), .CENTURY_RULE(1)) dut (
    .clk(clk), .rst(rst), .day_tick(day_tick), .load_valid(load_valid),
    .load_day(load_day), .load_month(load_month), .load_year(load_year),
    .adj_pulse(adj_pulse), .adj_sel(adj_sel),
    .day(day), .month(month), .year(year), .days_in_month(dim), .leap(leap),
    .load_ack(load_ack), .load_err(load_err), .month_wrap(month_wrap), .year_wrap(year_wrap)
  );

  calendar_date_counter #(.YEAR_W(7), .BASE_YEAR(2000), .CENTURY_RULE(0)) dut_c0 (
    .clk(clk), .rst(rst), .day_tick(day_tick), .load_valid(load_valid),
    .load_day(load_day), .load_month(load_month), .load_year(load_year),
    .adj_pulse(adj_pulse), .adj_sel(adj_sel),
    .day(day0), .month(month0), .year(year0), .days_in_month(dim0), .leap(leap0),
    .load_ack(ack0), .load_err(err0), .month_wrap(mw0), .year_wrap(yw0)
  );

  typedef struct {
    string      name;
    logic [4:0] d;
    logic [3:0] m;
    logic [6:0] y;
    logic [4:0] dim;
    logic       leap, ack, err, mw, yw;
    logic       chk0;
    logic [4:0] d0;
    logic [3:0] m0;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input logic r, input logic t, input logic lv, input logic [4:0] ld,
                       input logic [3:0] lm, input logic [6:0] ly, input logic ap, input logic [1:0] as);
    @(negedge clk);
    rst = r; day_tick = t; load_valid = lv; load_day = ld; load_month = lm;
    load_year = ly; adj_pulse = ap; adj_sel = as;
  endtask

  task automatic expect_st(input string name, input logic [4:0] d, input logic [3:0] m,
                           input logic [6:0] y, input logic [4:0] dm, input logic lp,
                           input logic ack, input logic err, input logic mw, input logic yw);
    exp_t e;
    e.name = name; e.d = d; e.m = m; e.y = y; e.dim = dm; e.leap = lp;
    e.ack = ack; e.err = err; e.mw = mw; e.yw = yw;
    e.chk0 = 1'b0; e.d0 = '0; e.m0 = '0;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    logic [28:0] got, want;
    forever begin
      @(posedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        #1;
        got  = {day, month, year, dim, leap, load_ack, load_err, month_wrap, year_wrap};
        want = {e.d, e.m, e.y, e.dim, e.leap, e.ack, e.err, e.mw, e.yw};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s: got d=%0d m=%0d y=%0d dim=%0d leap=%b ack=%b err=%b mw=%b yw=%b, want d=%0d m=%0d y=%0d dim=%0d leap=%b ack=%b err=%b mw=%b yw=%b",
                   e.name, day, month, year, dim, leap, load_ack, load_err, month_wrap, year_wrap,
                   e.d, e.m, e.y, e.dim, e.leap, e.ack, e.err, e.mw, e.yw);
        end else begin
          $display("ok   %s: d=%0d m=%0d y=%0d dim=%0d leap=%b ack=%b err=%b mw=%b yw=%b",
                   e.name, day, month, year, dim, leap, load_ack, load_err, month_wrap, year_wrap);
        end
        if (e.chk0) begin
          checks++;
          if ({day0, month0} !== {e.d0, e.m0}) begin
            errors++;
            $display("FAIL %s/div4-only: got d=%0d m=%0d, want d=%0d m=%0d", e.name, day0, month0, e.d0, e.m0);
          end else begin
            $display("ok   %s/div4-only: d=%0d m=%0d", e.name, day0, month0);
          end
        end
      end
    end
  end

  initial begin
    // rst, tick, load_valid, day, month, year, adj_pulse, adj_sel
    drive(1, 0, 1, 31, 1, 24, 0, 0); expect_st("reset_over_load", 1, 1, 0, 31, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 31, 1, 24, 0, 0); expect_st("load_2024_01_31", 31, 1, 24, 31, 1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);   expect_st("tick_to_feb01", 1, 2, 24, 29, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);   expect_st("idle_pulse_clear", 1, 2, 24, 29, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 28, 2, 23, 0, 0); expect_st("load_2023_02_28", 28, 2, 23, 28, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);   expect_st("tick_2023_to_mar", 1, 3, 23, 31, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 28, 2, 24, 0, 0); expect_st("load_2024_02_28", 28, 2, 24, 29, 1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);   expect_st("tick_to_feb29", 29, 2, 24, 29, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);   expect_st("tick_feb29_to_mar", 1, 3, 24, 31, 1, 0, 0, 1, 0);
    drive(0, 0, 1, 28, 2, 100, 0, 0); expect_st("load_2100_02_28", 28, 2, 100, 28, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);   expect_st("tick_2100_to_mar", 1, 3, 100, 31, 0, 0, 0, 1, 0);
    exp_q[exp_q.size()-1].chk0 = 1'b1;
    exp_q[exp_q.size()-1].d0 = 5'd29;
    exp_q[exp_q.size()-1].m0 = 4'd2;
    drive(0, 0, 1, 1, 1, 0, 0, 0);   expect_st("load_2000_leap", 1, 1, 0, 31, 1, 1, 0, 0, 0);
    drive(0, 0, 1, 31, 12, 127, 0, 0); expect_st("load_2127_12_31", 31, 12, 127, 31, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);   expect_st("tick_year_wrap", 1, 1, 0, 31, 1, 0, 0, 1, 1);
    drive(0, 0, 1, 31, 4, 23, 0, 0); expect_st("load_err_apr31", 1, 1, 0, 31, 1, 0, 1, 0, 0);
    drive(0, 0, 1, 29, 2, 23, 0, 0); expect_st("load_err_feb29_2023", 1, 1, 0, 31, 1, 0, 1, 0, 0);
    drive(0, 0, 1, 29, 2, 24, 0, 0); expect_st("load_ok_feb29_2024", 29, 2, 24, 29, 1, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 13, 23, 0, 0); expect_st("load_err_month13", 29, 2, 24, 29, 1, 0, 1, 0, 0);
    drive(0, 0, 1, 31, 1, 24, 0, 0); expect_st("load_2024_01_31b", 31, 1, 24, 31, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);   expect_st("adj_month_clamp29", 29, 2, 24, 29, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 2);   expect_st("adj_year_clamp28", 28, 2, 25, 28, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);   expect_st("adj_day_wrap", 1, 2, 25, 28, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 15, 12, 24, 0, 0); expect_st("load_2024_12_15", 15, 12, 24, 31, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);   expect_st("adj_month_dec_wrap", 15, 1, 24, 31, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 3);   expect_st("adj_none", 15, 1, 24, 31, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 31, 3, 30, 0, 0); expect_st("load_2030_03_31", 31, 3, 30, 31, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);   expect_st("adj_month_clamp30", 30, 4, 30, 30, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 30, 6, 30, 0, 0); expect_st("load_beats_tick", 30, 6, 30, 30, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 0);   expect_st("adj_beats_tick", 1, 6, 30, 30, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 10, 3, 127, 0, 0); expect_st("load_2127_03_10", 10, 3, 127, 31, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 2);   expect_st("adj_year_wrap_nopulse", 10, 3, 0, 31, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 5, 5, 5, 1, 0);   expect_st("reset_over_all", 1, 1, 0, 31, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);   expect_st("idle_after_reset", 1, 1, 0, 31, 1, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
